// File: rtl/multi_cycle_cpu.sv
// rtl/multi_cycle_cpu.sv - multi-cycle MIPS-I subset core with a shared request/ready memory port
module multi_cycle_cpu #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [5:0]  HALT_OPCODE = 6'h3F,
  parameter int          RETIRE_W    = 32
) (
  input  logic                clk,
  input  logic                reset,
  output logic                mem_req,
  output logic                mem_we,
  output logic [31:0]         mem_addr,
  output logic [31:0]         mem_wdata,
  input  logic [31:0]         mem_rdata,
  input  logic                mem_ready,
  output logic                halted,
  output logic                error,
  output logic [RETIRE_W-1:0] retired
);
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [RETIRE_W-1:0] RETIRE_ONE = {{(RETIRE_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

  state_t      state, next_state;
  logic [31:0] pc, ir, a, b, alu_out, mdr;
  logic        err_q;
  logic [31:0] regs [32];

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, wb_reg;
  logic [31:0] imm_sx, rs_val, rt_val, addr_sum, r_result, jump_target, wb_data;
  logic        funct_ok, branch_taken, is_legal_op, retire, reg_we;

  assign opcode      = ir[31:26];
  assign rs          = ir[25:21];
  assign rt          = ir[20:16];
  assign rd          = ir[15:11];
  assign funct       = ir[5:0];
  assign imm_sx      = {{16{ir[15]}}, ir[15:0]};
  assign rs_val      = (rs == 5'd0) ? 32'd0 : regs[rs];
  assign rt_val      = (rt == 5'd0) ? 32'd0 : regs[rt];
  assign addr_sum    = a + imm_sx;
  assign jump_target = {pc[31:28], ir[25:0], 2'b00};
  assign branch_taken = (opcode == OP_BEQ) ? ((a - b) == 32'd0) : ((a - b) != 32'd0);
  assign wb_reg      = (opcode == OP_RTYPE) ? rd : rt;
  assign wb_data     = (opcode == OP_LW) ? mdr : alu_out;
  assign reg_we      = (state == S_WB) && (wb_reg != 5'd0);
  assign halted      = (state == S_HALT);
  assign error       = err_q;

  always_comb begin
    is_legal_op = 1'b0;
    case (opcode)
      OP_RTYPE, OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_LW, OP_SW: is_legal_op = 1'b1;
      default: is_legal_op = 1'b0;
    endcase
  end

  always_comb begin
    r_result = 32'd0;
    funct_ok = 1'b1;
    case (funct)
      6'h20:   r_result = a + b;
      6'h22:   r_result = a - b;
      6'h24:   r_result = a & b;
      6'h25:   r_result = a | b;
      6'h2A:   r_result = {31'd0, $signed(a) < $signed(b)};
      default: funct_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= next_state;
  end

  // j/beq/bne retire out of EXEC, giving every control transfer the same 3-cycle cost
  always_comb begin
    next_state = state;
    retire     = 1'b0;
    case (state)
      S_FETCH:  if (mem_ready) next_state = S_DECODE;
      S_DECODE: next_state = is_legal_op ? S_EXEC : S_HALT;
      S_EXEC: begin
        case (opcode)
          OP_RTYPE:     next_state = funct_ok ? S_WB : S_HALT;
          OP_LW, OP_SW: next_state = (addr_sum[1:0] != 2'b00) ? S_HALT : S_MEM;
          OP_ADDI:      next_state = S_WB;
          default: begin
            next_state = S_FETCH;
            retire     = 1'b1;
          end
        endcase
      end
      S_MEM: begin
        if (mem_ready) begin
          if (opcode == OP_LW) begin
            next_state = S_WB;
          end else begin
            next_state = S_FETCH;
            retire     = 1'b1;
          end
        end
      end
      S_WB: begin
        next_state = S_FETCH;
        retire     = 1'b1;
      end
      S_HALT:  next_state = S_HALT;
      default: next_state = S_FETCH;
    endcase
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    if (!reset) begin
      case (state)
        S_FETCH: begin
          mem_req  = 1'b1;
          mem_addr = pc;
        end
        S_MEM: begin
          mem_req   = 1'b1;
          mem_addr  = alu_out;
          mem_we    = (opcode == OP_SW);
          mem_wdata = (opcode == OP_SW) ? b : 32'd0;
        end
        default: mem_req = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc      <= RESET_PC;
      ir      <= 32'd0;
      a       <= 32'd0;
      b       <= 32'd0;
      alu_out <= 32'd0;
      mdr     <= 32'd0;
      err_q   <= 1'b0;
      retired <= '0;
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
    end else begin
      if (retire) retired <= retired + RETIRE_ONE;
      if (reg_we) regs[wb_reg] <= wb_data;
      case (state)
        S_FETCH: begin
          if (mem_ready) begin
            ir <= mem_rdata;
            pc <= pc + 32'd4;
          end
        end
        S_DECODE: begin
          a       <= rs_val;
          b       <= rt_val;
          alu_out <= pc + {imm_sx[29:0], 2'b00};
          if (!is_legal_op && (opcode != HALT_OPCODE)) err_q <= 1'b1;
        end
        S_EXEC: begin
          case (opcode)
            OP_RTYPE: begin
              if (funct_ok) alu_out <= r_result;
              else          err_q   <= 1'b1;
            end
            OP_LW, OP_SW, OP_ADDI: begin
              alu_out <= addr_sum;
              if ((opcode != OP_ADDI) && (addr_sum[1:0] != 2'b00)) err_q <= 1'b1;
            end
            OP_BEQ, OP_BNE: if (branch_taken) pc <= alu_out;
            OP_J:           pc <= jump_target;
            default:        pc <= pc;
          endcase
        end
        S_MEM: if (mem_ready && (opcode == OP_LW)) mdr <= mem_rdata;
        default: mdr <= mdr;
      endcase
    end
  end
endmodule

// File: tb/tb_multi_cycle_cpu.sv
// tb/tb_multi_cycle_cpu.sv - bench for multi_cycle_cpu against an instruction-level reference model
module tb_multi_cycle_cpu;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] HALT_INS = {6'h3F, 26'd0};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req, mem_we, halted, error;
  logic [31:0] mem_addr, mem_wdata, retired;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_ready = 1'b0;

  multi_cycle_cpu #(.RESET_PC(RESET_PC), .HALT_OPCODE(6'h3F), .RETIRE_W(32)) dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .halted(halted), .error(error), .retired(retired)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  logic [31:0] mem [1024];
  logic [31:0] ref_mem [1024];
  logic [31:0] img [1024];
  int wait_fixed = 0;
  bit wait_rand = 0;
  int wcnt = 0, cur_wait = 0, cyc = 0, halt_cyc = -1;
  int waits_seen = 0, xfers_seen = 0, stable_err = 0;
  logic        log_req [4096];
  logic        log_we [4096];
  logic [31:0] log_addr [4096];
  logic        prev_wait = 1'b0, prev_we = 1'b0;
  logic [31:0] prev_addr = 32'd0, prev_wdata = 32'd0;

  function automatic logic [31:0] enc_i(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd, logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  // Memory side of the bus: wait states, reads, writes and bus-stability tracking, one cycle per call
  task automatic step_cycle();
    #1;
    mem_ready = mem_req && (wcnt >= cur_wait);
    mem_rdata = mem[mem_addr[11:2]];
    #1;
    if (cyc < 4096) begin
      log_req[cyc] = mem_req;
      log_we[cyc] = mem_we;
      log_addr[cyc] = mem_addr;
    end
    if (prev_wait && (!mem_req || mem_addr !== prev_addr || mem_we !== prev_we || mem_wdata !== prev_wdata))
      stable_err++;
    prev_wait = mem_req && !mem_ready;
    prev_addr = mem_addr;
    prev_we = mem_we;
    prev_wdata = mem_wdata;
    if (mem_req && mem_ready) begin
      xfers_seen++;
      if (mem_we) mem[mem_addr[11:2]] = mem_wdata;
      wcnt = 0;
      cur_wait = wait_rand ? int'($urandom_range(0, 2)) : wait_fixed;
    end else if (mem_req) begin
      wcnt++;
      waits_seen++;
    end else begin
      wcnt = 0;
    end
    if (halted === 1'b1 && halt_cyc < 0) halt_cyc = cyc;
    cyc++;
    @(negedge clk);
  endtask

  task automatic load_image();
    for (int i = 0; i < 1024; i++) begin
      mem[i] = img[i];
      ref_mem[i] = img[i];
    end
  endtask

  task automatic clear_image();
    for (int i = 0; i < 1024; i++) img[i] = 32'd0;
  endtask

  task automatic begin_run(input int w, input bit rnd);
    wait_fixed = w;
    wait_rand = rnd;
    cur_wait = rnd ? int'($urandom_range(0, 2)) : w;
    reset = 1'b1;
    step_cycle();
    step_cycle();
    reset = 1'b0;
    cyc = 0;
    wcnt = 0;
    waits_seen = 0;
    xfers_seen = 0;
    stable_err = 0;
    halt_cyc = -1;
    prev_wait = 1'b0;
  endtask

  task automatic run_to_halt(input int max_cycles);
    while (halt_cyc < 0 && cyc < max_cycles) step_cycle();
    tests_run++;
    if (halt_cyc < 0) begin
      tests_failed++;
      $display("FAIL halt_timeout: halted=%b after %0d cycles, required 1", halted, cyc);
    end
  endtask

  // Instruction-level reference: architectural effect plus cycle cost per instruction class
  task automatic ref_run(output int cyc_e, output int acc_e, output int ret_e, output bit err_e);
    logic [31:0] r [32];
    logic [31:0] pc, ins, sx, ea, v;
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd;
    bit done, ok;
    for (int i = 0; i < 32; i++) r[i] = 32'd0;
    pc = RESET_PC;
    cyc_e = 0; acc_e = 0; ret_e = 0; err_e = 1'b0; done = 1'b0;
    for (int n = 0; n < 5000 && !done; n++) begin
      ins = ref_mem[pc[11:2]];
      acc_e++;
      op = ins[31:26]; fn = ins[5:0];
      rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
      sx = {{16{ins[15]}}, ins[15:0]};
      pc = pc + 32'd4;
      ea = r[rs] + sx;
      case (op)
        6'h00: begin
          ok = 1'b1; v = 32'd0;
          case (fn)
            6'h20: v = r[rs] + r[rt];
            6'h22: v = r[rs] - r[rt];
            6'h24: v = r[rs] & r[rt];
            6'h25: v = r[rs] | r[rt];
            6'h2A: v = ($signed(r[rs]) < $signed(r[rt])) ? 32'd1 : 32'd0;
            default: ok = 1'b0;
          endcase
          if (ok) begin r[rd] = v; cyc_e += 4; ret_e++; end
          else begin err_e = 1'b1; cyc_e += 3; done = 1'b1; end
        end
        6'h08: begin r[rt] = ea; cyc_e += 4; ret_e++; end
        6'h23, 6'h2B: begin
          if (ea[1:0] != 2'b00) begin err_e = 1'b1; cyc_e += 3; done = 1'b1; end
          else begin
            acc_e++; ret_e++;
            if (op == 6'h23) begin r[rt] = ref_mem[ea[11:2]]; cyc_e += 5; end
            else begin ref_mem[ea[11:2]] = r[rt]; cyc_e += 4; end
          end
        end
        6'h04, 6'h05: begin
          if ((op == 6'h04) == (r[rs] == r[rt])) pc = pc + (sx << 2);
          cyc_e += 3; ret_e++;
        end
        6'h02: begin pc = {pc[31:28], ins[25:0], 2'b00}; cyc_e += 3; ret_e++; end
        6'h3F: begin cyc_e += 2; done = 1'b1; end
        default: begin err_e = 1'b1; cyc_e += 2; done = 1'b1; end
      endcase
      r[0] = 32'd0;
    end
  endtask

  task automatic build_spec_program();
    clear_image();
    img[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
    img[1] = enc_i(6'h08, 5'd0, 5'd2, 16'd7);
    img[2] = enc_r(5'd1, 5'd2, 5'd3, 6'h20);
    img[3] = enc_i(6'h2B, 5'd0, 5'd3, 16'h0040);
    img[4] = enc_i(6'h23, 5'd0, 5'd4, 16'h0040);
    img[5] = HALT_INS;
    load_image();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step_cycle();
    step_cycle();
    #1;
    tests_run++; if (mem_req !== 1'b0) begin tests_failed++; $display("FAIL reset_req: got %b required 0", mem_req); end
    tests_run++; if (mem_we !== 1'b0) begin tests_failed++; $display("FAIL reset_we: got %b required 0", mem_we); end
    tests_run++; if (mem_addr !== 32'd0) begin tests_failed++; $display("FAIL reset_addr: got %h required 0", mem_addr); end
    tests_run++; if (mem_wdata !== 32'd0) begin tests_failed++; $display("FAIL reset_wdata: got %h required 0", mem_wdata); end
    tests_run++; if (halted !== 1'b0 || error !== 1'b0) begin tests_failed++; $display("FAIL reset_flags: halted=%b error=%b required 0 0", halted, error); end
    tests_run++; if (retired !== 32'd0) begin tests_failed++; $display("FAIL reset_retired: got %0d required 0", retired); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    tests_run++;
    if (mem_req !== 1'b1 || mem_addr !== RESET_PC || mem_we !== 1'b0) begin
      tests_failed++;
      $display("FAIL first_fetch: req=%b we=%b addr=%h required 1 0 %h", mem_req, mem_we, mem_addr, RESET_PC);
    end
    @(negedge clk);
  endtask

  task automatic test_program(input int w);
    int cyc_e, acc_e, ret_e;
    bit err_e;
    build_spec_program();
    ref_run(cyc_e, acc_e, ret_e, err_e);
    begin_run(w, 1'b0);
    run_to_halt(1000);
    tests_run++; if (mem[16] !== 32'd12) begin tests_failed++; $display("FAIL prog_w%0d_mem40: got %0d required 12", w, mem[16]); end
    tests_run++; if (retired !== 32'd5) begin tests_failed++; $display("FAIL prog_w%0d_retired: got %0d required 5", w, retired); end
    tests_run++; if (halted !== 1'b1 || error !== 1'b0) begin tests_failed++; $display("FAIL prog_w%0d_flags: halted=%b error=%b required 1 0", w, halted, error); end
    tests_run++; if (halt_cyc != cyc_e + waits_seen) begin tests_failed++; $display("FAIL prog_w%0d_halt_cycle: got %0d required %0d", w, halt_cyc, cyc_e + waits_seen); end
    tests_run++; if (waits_seen != w * acc_e) begin tests_failed++; $display("FAIL prog_w%0d_waits: got %0d required %0d", w, waits_seen, w * acc_e); end
    tests_run++; if (stable_err != 0) begin tests_failed++; $display("FAIL prog_w%0d_bus_stable: got %0d changes during waits required 0", w, stable_err); end
    if (w == 0) begin
      tests_run++;
      if (log_req[21] !== 1'b1 || log_addr[21] !== 32'h14) begin
        tests_failed++;
        $display("FAIL prog_halt_fetch: cycle 21 req=%b addr=%h required 1 00000014", log_req[21], log_addr[21]);
      end
    end
  endtask

  task automatic test_branches();
    clear_image();
    img[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd3);
    img[1] = enc_i(6'h04, 5'd1, 5'd1, 16'd2);
    img[2] = enc_i(6'h08, 5'd0, 5'd5, 16'd1);
    img[3] = enc_i(6'h08, 5'd0, 5'd5, 16'd2);
    img[4] = enc_i(6'h05, 5'd1, 5'd1, 16'd1);
    img[5] = enc_i(6'h2B, 5'd0, 5'd1, 16'h0080);
    img[6] = HALT_INS;
    load_image();
    begin_run(0, 1'b0);
    run_to_halt(1000);
    tests_run++; if (log_req[7] !== 1'b1 || log_addr[7] !== 32'h10) begin tests_failed++; $display("FAIL beq_taken: cycle 7 req=%b addr=%h required 1 00000010", log_req[7], log_addr[7]); end
    tests_run++; if (log_req[10] !== 1'b1 || log_addr[10] !== 32'h14) begin tests_failed++; $display("FAIL bne_fallthrough: cycle 10 req=%b addr=%h required 1 00000014", log_req[10], log_addr[10]); end
    tests_run++; if (mem[32] !== 32'd3 || retired !== 32'd4) begin tests_failed++; $display("FAIL branch_result: mem80=%0d retired=%0d required 3 4", mem[32], retired); end
  endtask

  task automatic test_jump();
    clear_image();
    for (int i = 0; i < 4; i++) img[i] = enc_r(5'd0, 5'd0, 5'd0, 6'h20);
    img[4] = {6'h02, 26'h100};
    img[256] = HALT_INS;
    load_image();
    begin_run(0, 1'b0);
    run_to_halt(1000);
    tests_run++; if (log_addr[16] !== 32'h10) begin tests_failed++; $display("FAIL jump_fetch_pc: cycle 16 addr=%h required 00000010", log_addr[16]); end
    tests_run++; if (log_req[19] !== 1'b1 || log_addr[19] !== 32'h400) begin tests_failed++; $display("FAIL jump_target: cycle 19 req=%b addr=%h required 1 00000400", log_req[19], log_addr[19]); end
    tests_run++; if (retired !== 32'd5 || error !== 1'b0) begin tests_failed++; $display("FAIL jump_retired: retired=%0d error=%b required 5 0", retired, error); end
  endtask

  task automatic test_faults();
    int hits;
    clear_image();
    img[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd1);
    img[1] = {6'h3E, 26'd0};
    load_image();
    begin_run(1, 1'b0);
    run_to_halt(1000);
    tests_run++; if (halted !== 1'b1 || error !== 1'b1) begin tests_failed++; $display("FAIL illegal_op_flags: halted=%b error=%b required 1 1", halted, error); end
    tests_run++; if (retired !== 32'd1 || xfers_seen != 2) begin tests_failed++; $display("FAIL illegal_op_retired: retired=%0d transfers=%0d required 1 2", retired, xfers_seen); end
    clear_image();
    img[0] = enc_i(6'h23, 5'd0, 5'd2, 16'h0042);
    img[1] = HALT_INS;
    load_image();
    begin_run(0, 1'b0);
    run_to_halt(1000);
    hits = 0;
    for (int i = 0; i < cyc && i < 4096; i++) if (log_req[i] && log_addr[i] == 32'h42) hits++;
    tests_run++; if (halted !== 1'b1 || error !== 1'b1) begin tests_failed++; $display("FAIL misaligned_flags: halted=%b error=%b required 1 1", halted, error); end
    tests_run++; if (hits != 0 || retired !== 32'd0 || xfers_seen != 1) begin tests_failed++; $display("FAIL misaligned_access: requests_to_42=%0d retired=%0d transfers=%0d required 0 0 1", hits, retired, xfers_seen); end
  endtask

  task automatic test_reset_mid_sw();
    clear_image();
    img[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd9);
    img[1] = enc_i(6'h2B, 5'd0, 5'd1, 16'h0040);
    img[2] = HALT_INS;
    load_image();
    begin_run(6, 1'b0);
    while (!(cyc > 0 && log_req[cyc-1] && log_we[cyc-1]) && cyc < 200) step_cycle();
    tests_run++; if (cyc >= 200) begin tests_failed++; $display("FAIL sw_request_seen: no store request in %0d cycles, required one", cyc); end
    step_cycle();
    step_cycle();
    reset = 1'b1;
    step_cycle();
    reset = 1'b0;
    #1;
    tests_run++; if (mem[16] !== 32'd0) begin tests_failed++; $display("FAIL abort_no_write: mem40=%h required 0", mem[16]); end
    tests_run++; if (retired !== 32'd0) begin tests_failed++; $display("FAIL abort_retired: got %0d required 0", retired); end
    tests_run++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== RESET_PC) begin tests_failed++; $display("FAIL abort_refetch: req=%b we=%b addr=%h required 1 0 %h", mem_req, mem_we, mem_addr, RESET_PC); end
    @(negedge clk);
  endtask

  task automatic test_random(input int iters);
    int cyc_e, acc_e, ret_e, diffs, n;
    bit err_e;
    logic [4:0] rs, rt, rd;
    for (int it = 0; it < iters; it++) begin
      clear_image();
      n = 0;
      for (int i = 0; i < 12; i++) begin
        rs = 5'($urandom_range(0, 7)); rt = 5'($urandom_range(0, 7)); rd = 5'($urandom_range(0, 7));
        case ($urandom_range(0, 6))
          0: img[n] = enc_i(6'h08, rs, rt, 16'($urandom));
          1: img[n] = enc_r(rs, rt, rd, 6'h20);
          2: img[n] = enc_r(rs, rt, rd, 6'h22);
          3: img[n] = enc_r(rs, rt, rd, 6'h24);
          4: img[n] = enc_r(rs, rt, rd, 6'h25);
          5: img[n] = enc_r(rs, rt, rd, 6'h2A);
          default: img[n] = enc_i($urandom_range(0, 1) ? 6'h04 : 6'h05, rs, rt, 16'($urandom_range(0, 2)));
        endcase
        n++;
      end
      for (int k = 1; k < 8; k++) begin
        img[n] = enc_i(6'h2B, 5'd0, 5'(k), 16'(32'h200 + 4 * k));
        n++;
      end
      img[n] = enc_i(6'h23, 5'd0, 5'd1, 16'(32'h204 + 4 * $urandom_range(0, 6))); n++;
      img[n] = enc_i(6'h2B, 5'd0, 5'd1, 16'h0300); n++;
      img[n] = HALT_INS;
      load_image();
      ref_run(cyc_e, acc_e, ret_e, err_e);
      begin_run(0, 1'b1);
      run_to_halt(3000);
      diffs = 0;
      for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) diffs++;
      tests_run++; if (diffs != 0) begin tests_failed++; $display("FAIL rand%0d_memory: %0d words differ, required 0", it, diffs); end
      tests_run++; if (retired !== 32'(ret_e) || error !== err_e) begin tests_failed++; $display("FAIL rand%0d_retired: retired=%0d error=%b required %0d %b", it, retired, error, ret_e, err_e); end
      tests_run++; if (halt_cyc != cyc_e + waits_seen || xfers_seen != acc_e) begin tests_failed++; $display("FAIL rand%0d_timing: halt_cycle=%0d transfers=%0d required %0d %0d", it, halt_cyc, xfers_seen, cyc_e + waits_seen, acc_e); end
      tests_run++; if (stable_err != 0) begin tests_failed++; $display("FAIL rand%0d_bus_stable: %0d changes during waits, required 0", it, stable_err); end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_program(0);
    test_program(2);
    test_branches();
    test_jump();
    test_faults();
    test_reset_mid_sw();
    test_random(15);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
